// File: rtl/vlb_kill_join.sv
// rtl/vlb_kill_join.sv - N-channel kill merge / TTW response demux join (optional barrier timeout: KILL_TMO_EN)
// Bit0 kills OR across channels; bit1 kills form a sticky all-channel barrier.
module vlb_kill_join #(
  parameter int N       = 2,
  parameter int IDXW    = 6,
  parameter int MPNW    = 52,
  parameter int ATTRW   = 4,
  parameter int TMO_CYC = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2*N-1:0]      ch_kill_i,
  input  logic [N-1:0]        ch_req_valid_i,
  input  logic [N*IDXW-1:0]   ch_req_idx_i,
  output logic [N-1:0]        ch_req_valid_q_o,
  output logic [N*IDXW-1:0]   ch_req_idx_q_o,
  output logic [2:0]          kill_o,
  input  logic                ttw_valid_i,
  input  logic [IDXW-1:0]     ttw_idx_i,
  input  logic                ttw_vld_i,
  input  logic                ttw_err_i,
  input  logic [MPNW-1:0]     ttw_mpn_i,
  input  logic [ATTRW-1:0]    ttw_attr_i,
  input  logic                busy_i,
  output logic [N-1:0]        ch_ttw_valid_o,
  output logic [N-1:0]        ch_busy_o,
  output logic [IDXW-1:0]     ttw_idx_o,
  output logic                ttw_vld_o,
  output logic                ttw_err_o,
  output logic [MPNW-1:0]     ttw_mpn_o,
  output logic [ATTRW-1:0]    ttw_attr_o,
  output logic [N-1:0]        pend_o,
  output logic                tmo_o
);

  localparam int SELW = $clog2(N);

  logic [SELW-1:0]   sel;
  logic [N-1:0]      kill_b0, kill_b1;
  logic [N-1:0]      pend_q, pend_d;
  logic [N-1:0]      req_valid_q;
  logic [N*IDXW-1:0] req_idx_q;
  logic              flush, barrier, tmo;

  assign sel = ttw_idx_i[IDXW-1 -: SELW];

  // Owner decode; a select value at or above N matches no channel.
  always_comb begin
    ch_ttw_valid_o = '0;
    ch_busy_o      = '0;
    for (int c = 0; c < N; c++) begin
      ch_ttw_valid_o[c] = ttw_valid_i & (sel == SELW'(c));
      ch_busy_o[c]      = busy_i & (sel == SELW'(c));
    end
  end

  assign ttw_idx_o  = ttw_idx_i;
  assign ttw_vld_o  = ttw_vld_i;
  assign ttw_err_o  = ttw_err_i;
  assign ttw_mpn_o  = ttw_mpn_i;
  assign ttw_attr_o = ttw_attr_i;

  always_comb begin
    kill_b0 = '0;
    kill_b1 = '0;
    for (int c = 0; c < N; c++) begin
      kill_b0[c] = ch_kill_i[2*c];
      kill_b1[c] = ch_kill_i[2*c+1];
    end
  end

  assign flush   = |kill_b0;
  assign barrier = (&(kill_b1 | pend_q)) | tmo;
  // A request arriving in the release cycle is consumed by that release.
  assign pend_d  = barrier ? '0 : (pend_q | kill_b1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q      <= '0;
      req_valid_q <= '0;
      req_idx_q   <= '0;
    end else begin
      pend_q      <= pend_d;
      req_valid_q <= ch_req_valid_i;
      req_idx_q   <= ch_req_idx_i;
    end
  end

`ifdef KILL_TMO_EN
  localparam int CW = $clog2(TMO_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tmo   = (cnt_q == CW'(TMO_CYC));
  assign cnt_d = ((pend_q == '0) || barrier) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  assign kill_o           = {barrier, barrier, flush};
  assign pend_o           = pend_q;
  assign tmo_o            = tmo;
  assign ch_req_valid_q_o = req_valid_q;
  assign ch_req_idx_q_o   = req_idx_q;

endmodule
